wrr_arbiter: RTL

- Parametrised weighted round-robin arbiter. Successor to the fixed 4-requester round-robin arbiter.
- Generalises the requester count to N.
- Adds per-requester burst quotas (weights), grant hold until ack-counted release, and back-to-back re-arbitration with no idle cycle.
- Sits between N bus masters and one shared slave/port. Drives a registered one-hot grant plus encoded grant index.

---
 rtl/wrr_arb_pkg.sv | 15 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/wrr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

    // Arbiter FSM: either nobody owns the port, or one requester does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // A zero quota still buys one beat, so an owner can always make progress.
    function automatic int unsigned clamp_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage : wrr_arb_pkg

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set bit of req starting at ptr, wrapping.
module rr_priority_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;

    // Double the request vector, mask off everything below ptr in the low copy,
    // then take the lowest set bit; the high copy supplies the wrapped part.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        req2   = {req, req};
        mask   = ~(((2*N)'(1) << ptr) - (2*N)'(1));
        masked = req2 & mask;
        found  = 1'b0;
        idx    = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                idx   = IDW'(i % N);
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, per-requester burst quotas,
// grant held until the quota is acked out or the owner drops its request.
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic [WW-1:0]   credit
);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [WW-1:0]  credit_q, credit_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [WW-1:0]  pick_weight;
    logic           release_now;

    // Pointer the owner leaves behind on release: it drops to lowest priority.
    assign next_ptr = (gnt_id_q == IDW'(N-1)) ? '0 : gnt_id_q + IDW'(1);

    // While granted, the picker only matters on release, so it always looks
    // from next_ptr; while idle it looks from the stored pointer.
    assign pick_ptr = (state_q == GRANT) ? next_ptr : ptr_q;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_weight = weight[pick_idx*WW +: WW];

    // A dropped request and the final acked beat are the same single release.
    assign release_now = !req[gnt_id_q] || (ack && credit_q == WW'(1));

    // Next-state logic: idle arbitration, credit countdown, and release with
    // same-edge re-arbitration so back-to-back grants have no idle cycle.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    gnt_d    = N'(1) << pick_idx;
                    gnt_id_d = pick_idx;
                    credit_d = WW'(clamp_weight(32'(pick_weight)));
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        gnt_d    = N'(1) << pick_idx;
                        gnt_id_d = pick_idx;
                        credit_d = WW'(clamp_weight(32'(pick_weight)));
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        credit_d = '0;
                    end
                end else if (ack) begin
                    credit_d = credit_q - WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            credit_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign credit    = credit_q;

endmodule : wrr_arbiter
